// File: rtl/hazard_unit_param_if.sv
// ============================================================================
// Module : hazard_unit_param_if
// Brief  : Pipeline-side bundle of the hazard unit (ID/EX/MEM/WB info in,
//          stall/flush/forward controls out).
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface hazard_unit_param_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [REG_W-1:0] rs_id;
    logic [REG_W-1:0] rt_id;
    logic             uses_rs_id;
    logic             uses_rt_id;
    logic [REG_W-1:0] rt_ex;
    logic             mem_to_reg_ex;
    logic [REG_W-1:0] rs_ex;
    logic [REG_W-1:0] rt_ex_src;
    logic [REG_W-1:0] rd_mem;
    logic             reg_write_mem;
    logic [REG_W-1:0] rd_wb;
    logic             reg_write_wb;
    logic             branch_taken;
    logic             stall;
    logic             bubble_ex;
    logic             flush;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_valid, rs_id, rt_id, uses_rs_id, uses_rt_id,
               rt_ex, mem_to_reg_ex, rs_ex, rt_ex_src,
               rd_mem, reg_write_mem, rd_wb, reg_write_wb, branch_taken,
        input  stall, bubble_ex, flush, fwd_a, fwd_b, stall_cycles
    );

    modport slave (
        input  id_valid, rs_id, rt_id, uses_rs_id, uses_rt_id,
               rt_ex, mem_to_reg_ex, rs_ex, rt_ex_src,
               rd_mem, reg_write_mem, rd_wb, reg_write_wb, branch_taken,
        output stall, bubble_ex, flush, fwd_a, fwd_b, stall_cycles
    );
endinterface

`default_nettype wire

// File: rtl/hazard_unit_param.sv
// ============================================================================
// Module : hazard_unit_param
// Brief  : Load-use stall (LOAD_LAT cycles), branch flush, EX forwarding
//          selects and a saturating stall-cycle counter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module hazard_unit_param #(
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = 1,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    hazard_unit_param_if.slave    bus
);

    localparam logic [3:0] c_CNT_INIT = (LOAD_LAT > 1) ? 4'(LOAD_LAT - 2) : 4'd0;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic [CNT_W-1:0] r_stall_cycles;

    logic w_detect;
    logic w_stall;

    // Exact compare; register 0 is hardwired and never a real producer.
    function automatic logic f_match(input logic [REG_W-1:0] x,
                                     input logic [REG_W-1:0] y);
        return (x == y) && !((ZERO_REG != 0) && (x == '0));
    endfunction

    always_comb begin
        w_detect = bus.id_valid & bus.mem_to_reg_ex &
                   ((bus.uses_rs_id & f_match(bus.rs_id, bus.rt_ex)) |
                    (bus.uses_rt_id & f_match(bus.rt_id, bus.rt_ex)));
        if (bus.branch_taken)
            w_stall = 1'b0;
        else if (r_state == S_HOLD)
            w_stall = 1'b1;
        else
            w_stall = w_detect;
    end

    always_comb begin
        bus.fwd_a = 2'b00;
        if (bus.reg_write_mem && f_match(bus.rs_ex, bus.rd_mem))
            bus.fwd_a = 2'b10;
        else if (bus.reg_write_wb && f_match(bus.rs_ex, bus.rd_wb))
            bus.fwd_a = 2'b01;

        bus.fwd_b = 2'b00;
        if (bus.reg_write_mem && f_match(bus.rt_ex_src, bus.rd_mem))
            bus.fwd_b = 2'b10;
        else if (bus.reg_write_wb && f_match(bus.rt_ex_src, bus.rd_wb))
            bus.fwd_b = 2'b01;
    end

    assign bus.stall        = w_stall;
    assign bus.bubble_ex    = w_stall;
    assign bus.flush        = bus.branch_taken;
    assign bus.stall_cycles = r_stall_cycles;

    // The first stall cycle is combinational from IDLE; HOLD supplies the rest.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_cnt          <= 4'd0;
            r_stall_cycles <= '0;
        end else begin
            if (w_stall && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);

            case (r_state)
                S_IDLE: begin
                    if (w_stall && (LOAD_LAT > 1)) begin
                        r_state <= S_HOLD;
                        r_cnt   <= c_CNT_INIT;
                    end
                end
                S_HOLD: begin
                    if (bus.branch_taken) begin
                        r_state <= S_IDLE;
                        r_cnt   <= 4'd0;
                    end else if (r_cnt == 4'd0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit_param.sv
// ============================================================================
// Module : tb_hazard_unit_param
// Brief  : Directed bench for hazard_unit_param at LOAD_LAT 1, 3 and 4.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_unit_param;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    hazard_unit_param_if #(.REG_W(5), .CNT_W(16)) if_a ();
    hazard_unit_param_if #(.REG_W(5), .CNT_W(16)) if_b ();
    hazard_unit_param_if #(.REG_W(5), .CNT_W(4))  if_c ();

    hazard_unit_param #(.REG_W(5), .LOAD_LAT(1), .ZERO_REG(1), .CNT_W(16)) u_lat1 (
        .clk (clk), .rst (rst), .bus (if_a)
    );
    hazard_unit_param #(.REG_W(5), .LOAD_LAT(3), .ZERO_REG(1), .CNT_W(16)) u_lat3 (
        .clk (clk), .rst (rst), .bus (if_b)
    );
    hazard_unit_param #(.REG_W(5), .LOAD_LAT(4), .ZERO_REG(1), .CNT_W(4)) u_lat4 (
        .clk (clk), .rst (rst), .bus (if_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst     = 1'b0;
        {if_a.id_valid, if_a.rs_id, if_a.rt_id, if_a.uses_rs_id, if_a.uses_rt_id, if_a.rt_ex,
         if_a.mem_to_reg_ex, if_a.rs_ex, if_a.rt_ex_src, if_a.rd_mem, if_a.reg_write_mem,
         if_a.rd_wb, if_a.reg_write_wb, if_a.branch_taken} = '0;
        {if_b.id_valid, if_b.rs_id, if_b.rt_id, if_b.uses_rs_id, if_b.uses_rt_id, if_b.rt_ex,
         if_b.mem_to_reg_ex, if_b.rs_ex, if_b.rt_ex_src, if_b.rd_mem, if_b.reg_write_mem,
         if_b.rd_wb, if_b.reg_write_wb, if_b.branch_taken} = '0;
        {if_c.id_valid, if_c.rs_id, if_c.rt_id, if_c.uses_rs_id, if_c.uses_rt_id, if_c.rt_ex,
         if_c.mem_to_reg_ex, if_c.rs_ex, if_c.rt_ex_src, if_c.rd_mem, if_c.reg_write_mem,
         if_c.rd_wb, if_c.reg_write_wb, if_c.branch_taken} = '0;

        step();
        step();
        chk("rst_cnt_a", 32'(if_a.stall_cycles), 0);
        chk("rst_cnt_c", 32'(if_c.stall_cycles), 0);
        chk("rst_stall_b", 32'(if_b.stall), 0);
        chk("rst_fwd_a", 32'(if_a.fwd_a), 0);
        rst = 1'b1;
        step();

        // Single-cycle stall at LOAD_LAT=1
        if_a.id_valid = 1'b1; if_a.mem_to_reg_ex = 1'b1; if_a.rt_ex = 5'd5;
        if_a.rs_id = 5'd5; if_a.uses_rs_id = 1'b1;
        #1;
        chk("l1_stall", 32'(if_a.stall), 1);
        chk("l1_bubble", 32'(if_a.bubble_ex), 1);
        chk("l1_cnt0", 32'(if_a.stall_cycles), 0);
        step();
        chk("l1_cnt1", 32'(if_a.stall_cycles), 1);
        if_a.mem_to_reg_ex = 1'b0;
        #1;
        chk("l1_release", 32'(if_a.stall), 0);
        step();
        chk("l1_cnt_hold", 32'(if_a.stall_cycles), 1);

        // Three-cycle stall at LOAD_LAT=3
        if_b.id_valid = 1'b1; if_b.mem_to_reg_ex = 1'b1; if_b.rt_ex = 5'd5;
        if_b.rs_id = 5'd5; if_b.uses_rs_id = 1'b1;
        #1;
        chk("l3_c0", 32'(if_b.stall), 1);
        step();
        if_b.mem_to_reg_ex = 1'b0;
        #1;
        chk("l3_c1", 32'(if_b.stall), 1);
        step();
        chk("l3_c2", 32'(if_b.bubble_ex), 1);
        step();
        chk("l3_c3", 32'(if_b.stall), 0);
        chk("l3_cnt", 32'(if_b.stall_cycles), 3);
        step();
        chk("l3_c4", 32'(if_b.stall), 0);

        // Zero register and non-matching addresses
        if_a.mem_to_reg_ex = 1'b1; if_a.rt_ex = 5'd0; if_a.rs_id = 5'd0;
        #1;
        chk("zr_no_stall", 32'(if_a.stall), 0);
        if_a.rs_id = 5'd3; if_a.rt_ex = 5'd7;
        #1;
        chk("xnor_case", 32'(if_a.stall), 0);
        if_a.rt_id = 5'd7; if_a.uses_rt_id = 1'b1;
        #1;
        chk("rt_match", 32'(if_a.stall), 1);
        if_a.id_valid = 1'b0;
        #1;
        chk("invalid_id", 32'(if_a.stall), 0);
        if_a.id_valid = 1'b1; if_a.branch_taken = 1'b1;
        #1;
        chk("br_flush", 32'(if_a.flush), 1);
        chk("br_kill_stall", 32'(if_a.stall), 0);
        if_a.mem_to_reg_ex = 1'b0; if_a.branch_taken = 1'b0; if_a.uses_rt_id = 1'b0;

        // Branch aborts a LOAD_LAT=4 stall on its second cycle
        if_c.id_valid = 1'b1; if_c.mem_to_reg_ex = 1'b1; if_c.rt_ex = 5'd5;
        if_c.rs_id = 5'd5; if_c.uses_rs_id = 1'b1;
        #1;
        chk("l4_c0", 32'(if_c.stall), 1);
        step();
        if_c.mem_to_reg_ex = 1'b0; if_c.branch_taken = 1'b1;
        #1;
        chk("l4_flush", 32'(if_c.flush), 1);
        chk("l4_br_stall", 32'(if_c.stall), 0);
        chk("l4_br_bubble", 32'(if_c.bubble_ex), 0);
        step();
        if_c.branch_taken = 1'b0;
        #1;
        chk("l4_idle", 32'(if_c.stall), 0);
        chk("l4_noflush", 32'(if_c.flush), 0);
        chk("l4_cnt", 32'(if_c.stall_cycles), 1);
        step();
        chk("l4_idle2", 32'(if_c.stall), 0);

        // Forwarding selects
        if_a.rs_ex = 5'd8; if_a.rt_ex_src = 5'd8; if_a.rd_mem = 5'd8; if_a.rd_wb = 5'd8;
        if_a.reg_write_mem = 1'b1; if_a.reg_write_wb = 1'b1;
        #1;
        chk("fwd_a_mem", 32'(if_a.fwd_a), 32'b10);
        chk("fwd_b_mem", 32'(if_a.fwd_b), 32'b10);
        if_a.reg_write_mem = 1'b0;
        #1;
        chk("fwd_a_wb", 32'(if_a.fwd_a), 32'b01);
        chk("fwd_b_wb", 32'(if_a.fwd_b), 32'b01);
        if_a.reg_write_mem = 1'b1; if_a.rs_ex = 5'd0; if_a.rd_mem = 5'd0; if_a.rd_wb = 5'd0;
        if_a.rt_ex_src = 5'd3;
        #1;
        chk("fwd_a_zero", 32'(if_a.fwd_a), 32'b00);
        chk("fwd_b_none", 32'(if_a.fwd_b), 32'b00);
        if_a.rd_mem = 5'd3;
        #1;
        chk("fwd_b_mem2", 32'(if_a.fwd_b), 32'b10);
        chk("fwd_a_zero2", 32'(if_a.fwd_a), 32'b00);

        // Saturation with back-to-back hazards (counter already at 1)
        if_c.mem_to_reg_ex = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("sat_mid", 32'(if_c.stall_cycles), 6);
        for (int i = 0; i < 15; i++) step();
        chk("sat_top", 32'(if_c.stall_cycles), 15);
        step();
        chk("sat_hold", 32'(if_c.stall_cycles), 15);

        // Asynchronous reset in the middle of HOLD
        if_c.mem_to_reg_ex = 1'b0;
        #1;
        chk("hold_stall", 32'(if_c.stall), 1);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_async_stall", 32'(if_c.stall), 0);
        chk("rst_async_cnt", 32'(if_c.stall_cycles), 0);
        if_c.mem_to_reg_ex = 1'b1;
        #1;
        chk("rst_comb_detect", 32'(if_c.stall), 1);
        step();
        chk("rst_cnt_frozen", 32'(if_c.stall_cycles), 0);
        if_c.mem_to_reg_ex = 1'b0;
        rst = 1'b1;
        step();
        chk("post_rst_idle", 32'(if_c.stall), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
